ps2_cmd_sched: RTL and testbench
================================

Name: ps2_cmd_sched

Overview:
- Host-to-keyboard command sequencer between the PS/2 link core and its command requesters: LED sync, typematic rate, keyboard reset.
- Latches requests and arbitrates them onto the core's single send interface.
- Runs two-byte command/argument transactions, consuming ACK (FA), RESEND (FE) and BAT (AA) replies.
- Passes every other received byte to the scancode decoder unchanged.

Parameters:
- ACK_TIMEOUT, 2500000, clk50 cycles to wait for a reply after a byte is sent (50 ms @ 50 MHz).
- MAX_RETRY, 3, RESEND/timeout retries per byte before the transaction is abandoned.
- CNT_W, 22, width of the timeout counter; must hold ACK_TIMEOUT.

Ports:
- clk50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- led_req  in  1  pulse: LED state changed.
- led_val  in  3  {caps,numlock,scrlock}, sampled at grant.
- rate_req  in  1  pulse: set typematic rate.
- rate_val  in  8  typematic argument byte, sampled at grant.
- kbd_rst_req  in  1  pulse: send keyboard reset (FF).
- busy  out  1  transaction in progress.
- done  out  1  1-cycle pulse: transaction completed OK.
- err  out  1  1-cycle pulse: transaction abandoned.
- grant  out  2  active requester: 0 none, 1 reset, 2 LED, 3 rate.
- cmd_byte  out  8  byte to the PS/2 core (the_command).
- cmd_send  out  1  send strobe to the core (send_command).
- cmd_sent  in  1  core: byte transmitted (command_was_sent).
- cmd_tmo  in  1  core: transmit timed out.
- rx_data  in  8  core received byte.
- rx_en  in  1  core: rx_data valid, 1-cycle pulse.
- key_data  out  8  filtered byte to the scancode decoder.
- key_en  out  1  key_data valid, 1-cycle pulse.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, pending bits, retry and timeout counters cleared. Reset mid-transaction aborts immediately; no done/err pulse.
- Pending bits:
  - Set on req pulse; cleared when the requester is granted.
  - A req arriving while its own transaction is in flight re-sets its pending bit, so one more transaction follows. Values are sampled at the later grant, so the latest value wins.
- Priority: reset > LED > rate. Fixed, evaluated only in IDLE.
- FSM: IDLE -> TX_CMD -> WAIT_REL -> WAIT_ACK -> [TX_ARG -> WAIT_REL -> WAIT_ACK] -> IDLE.
- Command bytes: reset FF, no argument. LED ED, argument {5'b0,led_val}. Rate F3, argument rate_val.
- Send handshake:
  - TX_*: drive cmd_byte and hold cmd_send=1 until cmd_sent or cmd_tmo.
  - WAIT_REL: cmd_send=0 until cmd_sent is low, so the core always sees a falling strobe (at least 1 cycle) between bytes.
- WAIT_ACK: timeout counter runs from 0. Outcomes:
  - rx_en with rx_data=FA: byte accepted. Go to the next byte, or finish with done.
  - rx_en with FE, cmd_tmo during TX, or counter reaching ACK_TIMEOUT-1: retry the same byte (back to TX_ of the same byte). Once MAX_RETRY retries are exhausted: err, go to IDLE.
- Filtering:
  - rx_en while IDLE: key_en=rx_en, key_data=rx_data, same cycle (combinational path, zero latency).
  - In WAIT_ACK, FA/FE are consumed (key_en=0). Any other byte passes through, since scancodes may interleave before an ACK.
  - AA is consumed only in WAIT_BAT.
- busy=1 whenever the state is not IDLE. grant holds its value for the whole transaction and returns to 0 in IDLE.
- done/err fire on the cycle the FSM enters IDLE; a new grant is possible on the next cycle.

Optional Feature:
- PS2_BAT_WAIT_EN defined:
  - After the FF ACK, add state WAIT_BAT.
  - rx AA gives done. rx FC or timeout gives err.
  - The LED pending bit is forced to 1 on exit, to re-sync the LEDs.
- Not defined: reset completes at the FF ACK, and AA passes to key_data.

Decomposition:
- Shared package ps2_pkg:
  - Byte constants: CMD_RESET=FF, CMD_LED=ED, CMD_RATE=F3, RSP_ACK=FA, RSP_RESEND=FE, RSP_BAT=AA, RSP_BATFAIL=FC.
  - FSM state enum; grant encoding.
- Sub-module ps2_tmo_cnt: timeout counter with clear/expire.

Test Plan:
- led_req with led_val=3'b101 -> cmd ED; after FA -> cmd 05; after FA -> done pulse, grant returns to 0, no key_en for either FA.
- led_req and rate_req in the same cycle, rate_val=20 -> LED transaction completes first, then F3, 20; two done pulses.
- ED answered by FE, FE, then FA -> ED sent 3 times total, then argument sent, done; four consecutive FE -> err after 4 sends (MAX_RETRY=3).
- No reply after F3 with ACK_TIMEOUT=100 -> resend at cycle 100, err after 3 retries; key byte 1C arriving mid-wait -> key_en=1, key_data=1C.
- kbd_rst_req with PS2_BAT_WAIT_EN, replies FA then AA -> done, then automatic ED transaction; without the macro -> done after FA, and AA appears on key_data.
- reset asserted during WAIT_ACK of ED -> cmd_send=0, busy=0 immediately, no done/err, pending bits cleared.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 host command path: command and
// response byte values, the sequencer state encoding and the requester grant
// encoding with its fixed priority.
package ps2_pkg;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_LED     = 8'hED;
    localparam logic [7:0] CMD_RATE    = 8'hF3;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;
    localparam logic [7:0] RSP_BAT     = 8'hAA;
    localparam logic [7:0] RSP_BATFAIL = 8'hFC;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_CMD   = 3'd1,
        ST_WAIT_REL = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_TX_ARG   = 3'd4,
        ST_WAIT_BAT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RST  = 2'd1,
        GNT_LED  = 2'd2,
        GNT_RATE = 2'd3
    } grant_t;

    // Fixed priority: keyboard reset beats LED sync beats typematic rate.
    function automatic grant_t pick_grant(input logic p_rst, input logic p_led,
                                          input logic p_rate);
        if (p_rst)       return GNT_RST;
        else if (p_led)  return GNT_LED;
        else if (p_rate) return GNT_RATE;
        else             return GNT_NONE;
    endfunction

    // Command opcode sent as the first byte of each transaction.
    function automatic logic [7:0] cmd_of(input grant_t g);
        case (g)
            GNT_RST:  return CMD_RESET;
            GNT_LED:  return CMD_LED;
            GNT_RATE: return CMD_RATE;
            default:  return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ps2_tmo_cnt.sv
// Reply timeout counter: cleared on every sequencer state change, counts while
// the sequencer waits for a reply and holds once it reaches LIMIT-1.
module ps2_tmo_cnt #(
    parameter int CNT_W = 22,
    parameter int LIMIT = 2500000
) (
    input  logic clk50,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    assign expire = (cnt == CNT_W'(LIMIT - 1));

    // Count up while waiting; saturate at the expiry value.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset)                cnt <= '0;
        else if (clr)             cnt <= '0;
        else if (run && !expire)  cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/ps2_cmd_sched.sv
// Host-to-keyboard command sequencer. Latches LED / typematic / reset
// requests, grants them by fixed priority and runs command(+argument)
// transactions over the PS/2 core's single send port, retrying on RESEND,
// transmit timeout or reply timeout. ACK/RESEND replies are swallowed while
// waiting for them; every other received byte goes straight to key_data.
// Optional: define PS2_BAT_WAIT_EN to wait for the keyboard self-test result
// (AA/FC) after the reset command and then re-sync the LEDs.
module ps2_cmd_sched
    import ps2_pkg::*;
#(
    parameter int ACK_TIMEOUT = 2500000,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 22
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       led_req,
    input  logic [2:0] led_val,
    input  logic       rate_req,
    input  logic [7:0] rate_val,
    input  logic       kbd_rst_req,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] grant,
    output logic [7:0] cmd_byte,
    output logic       cmd_send,
    input  logic       cmd_sent,
    input  logic       cmd_tmo,
    input  logic [7:0] rx_data,
    input  logic       rx_en,
    output logic [7:0] key_data,
    output logic       key_en
);

    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t           state, nstate;
    grant_t           gnt, pick;
    logic             pend_rst, pend_led, pend_rate;
    logic [7:0]       arg;
    logic             on_arg;      // current byte is the argument byte
    logic             retx;        // WAIT_REL should re-send rather than await a reply
    logic [RTY_W-1:0] retry;
    logic             tmo_exp, last_try, take;
    logic             fin_ok, fin_err, rty_inc, tx_fail, next_byte, led_resync;
    logic             is_ack, is_resend;
    logic             done_q, err_q;
`ifdef PS2_BAT_WAIT_EN
    logic             is_bat, is_batfail;
    assign is_bat     = rx_en && (rx_data == RSP_BAT);
    assign is_batfail = rx_en && (rx_data == RSP_BATFAIL);
`endif

    assign is_ack    = rx_en && (rx_data == RSP_ACK);
    assign is_resend = rx_en && (rx_data == RSP_RESEND);
    assign last_try  = (retry == RTY_W'(MAX_RETRY));
    assign pick      = pick_grant(pend_rst, pend_led, pend_rate);
    assign take      = (state == ST_IDLE) && (pick != GNT_NONE);
    assign grant     = gnt;
    assign done      = done_q;
    assign err       = err_q;

    ps2_tmo_cnt #(.CNT_W(CNT_W), .LIMIT(ACK_TIMEOUT)) u_tmo (
        .clk50  (clk50),
        .reset  (reset),
        .clr    (nstate != state),
        .run    ((state == ST_WAIT_ACK) || (state == ST_WAIT_BAT)),
        .expire (tmo_exp)
    );

    // State register.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= nstate;
    end

    // Next state plus the per-cycle transaction events.
    always_comb begin
        nstate     = state;
        fin_ok     = 1'b0;
        fin_err    = 1'b0;
        rty_inc    = 1'b0;
        tx_fail    = 1'b0;
        next_byte  = 1'b0;
        led_resync = 1'b0;
        case (state)
            ST_IDLE: if (take) nstate = ST_TX_CMD;
            ST_TX_CMD, ST_TX_ARG: begin
                if (cmd_tmo) begin
                    if (last_try) begin
                        nstate  = ST_IDLE;
                        fin_err = 1'b1;
                    end else begin
                        nstate  = ST_WAIT_REL;
                        rty_inc = 1'b1;
                        tx_fail = 1'b1;
                    end
                end else if (cmd_sent) begin
                    nstate = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (!cmd_sent)
                    nstate = retx ? (on_arg ? ST_TX_ARG : ST_TX_CMD) : ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (is_ack) begin
                    if (!on_arg && (gnt != GNT_RST)) begin
                        nstate    = ST_TX_ARG;
                        next_byte = 1'b1;
                    end
`ifdef PS2_BAT_WAIT_EN
                    else if (gnt == GNT_RST) begin
                        nstate = ST_WAIT_BAT;
                    end
`endif
                    else begin
                        nstate = ST_IDLE;
                        fin_ok = 1'b1;
                    end
                end else if (is_resend || tmo_exp) begin
                    if (last_try) begin
                        nstate  = ST_IDLE;
                        fin_err = 1'b1;
                    end else begin
                        nstate  = on_arg ? ST_TX_ARG : ST_TX_CMD;
                        rty_inc = 1'b1;
                    end
                end
            end
`ifdef PS2_BAT_WAIT_EN
            ST_WAIT_BAT: begin
                if (is_bat) begin
                    nstate     = ST_IDLE;
                    fin_ok     = 1'b1;
                    led_resync = 1'b1;
                end else if (is_batfail || tmo_exp) begin
                    nstate     = ST_IDLE;
                    fin_err    = 1'b1;
                    led_resync = 1'b1;
                end
            end
`endif
            default: nstate = ST_IDLE;
        endcase
    end

    // Send port, busy flag and the receive filter toward the scancode decoder.
    always_comb begin
        busy     = (state != ST_IDLE);
        cmd_send = 1'b0;
        cmd_byte = 8'h00;
        key_en   = rx_en;
        case (state)
            ST_TX_CMD: begin
                cmd_send = 1'b1;
                cmd_byte = cmd_of(gnt);
            end
            ST_TX_ARG: begin
                cmd_send = 1'b1;
                cmd_byte = arg;
            end
            ST_WAIT_ACK: if (is_ack || is_resend) key_en = 1'b0;
`ifdef PS2_BAT_WAIT_EN
            ST_WAIT_BAT: if (is_bat || is_batfail) key_en = 1'b0;
`endif
            default: ;
        endcase
        key_data = key_en ? rx_data : 8'h00;
    end

    // Pending requests, grant/argument capture, retry bookkeeping, result pulses.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            pend_rst  <= 1'b0;
            pend_led  <= 1'b0;
            pend_rate <= 1'b0;
            gnt       <= GNT_NONE;
            arg       <= 8'h00;
            on_arg    <= 1'b0;
            retx      <= 1'b0;
            retry     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q    <= fin_ok;
            err_q     <= fin_err;
            // A request landing in the grant cycle survives, queueing one more run.
            pend_rst  <= (pend_rst  && !(take && pick == GNT_RST))  || kbd_rst_req;
            pend_led  <= (pend_led  && !(take && pick == GNT_LED))  || led_req || led_resync;
            pend_rate <= (pend_rate && !(take && pick == GNT_RATE)) || rate_req;
            if (take) begin
                gnt    <= pick;
                arg    <= (pick == GNT_LED) ? {5'b0, led_val} : rate_val;
                on_arg <= 1'b0;
                retx   <= 1'b0;
                retry  <= '0;
            end else begin
                if (nstate == ST_IDLE) gnt <= GNT_NONE;
                if (next_byte) begin
                    on_arg <= 1'b1;
                    retry  <= '0;
                end else if (rty_inc) begin
                    retry  <= retry + 1'b1;
                end
                if (tx_fail)                                  retx <= 1'b1;
                else if (state == ST_WAIT_REL && !cmd_sent)   retx <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sched.sv
// Directed bench for ps2_cmd_sched with a 100-cycle reply timeout. The
// keyboard-reset step follows whichever PS2_BAT_WAIT_EN build is compiled.
module tb_ps2_cmd_sched;

    logic       clk50 = 1'b0;
    logic       reset = 1'b1;
    logic       led_req = 1'b0, rate_req = 1'b0, kbd_rst_req = 1'b0;
    logic [2:0] led_val = 3'b000;
    logic [7:0] rate_val = 8'h00;
    logic       busy, done, err, cmd_send, key_en;
    logic [1:0] grant;
    logic [7:0] cmd_byte, key_data;
    logic       cmd_sent = 1'b0, cmd_tmo = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en = 1'b0;

    int checks = 0;
    int errors = 0;

    ps2_cmd_sched #(.ACK_TIMEOUT(100), .MAX_RETRY(3), .CNT_W(22)) dut (
        .clk50(clk50), .reset(reset),
        .led_req(led_req), .led_val(led_val),
        .rate_req(rate_req), .rate_val(rate_val),
        .kbd_rst_req(kbd_rst_req),
        .busy(busy), .done(done), .err(err), .grant(grant),
        .cmd_byte(cmd_byte), .cmd_send(cmd_send),
        .cmd_sent(cmd_sent), .cmd_tmo(cmd_tmo),
        .rx_data(rx_data), .rx_en(rx_en),
        .key_data(key_data), .key_en(key_en)
    );

    always #10 clk50 = ~clk50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for the strobe, check the byte, then answer with a one-cycle cmd_sent.
    task automatic expect_send(input string tag, input logic [7:0] b);
        int k;
        k = 0;
        do begin
            @(negedge clk50);
            k++;
        end while (!cmd_send && k < 300);
        chk({tag, " send"}, {31'b0, cmd_send}, 32'd1);
        chk({tag, " byte"}, {24'b0, cmd_byte}, {24'b0, b});
        cmd_sent = 1'b1;
        @(negedge clk50);
        cmd_sent = 1'b0;
        chk({tag, " strobe_low"}, {31'b0, cmd_send}, 32'd0);
    endtask

    // One received byte; key_en is combinational so it is checked in the same cycle.
    task automatic reply(input string tag, input logic [7:0] b, input logic exp_key);
        @(negedge clk50);
        rx_data = b;
        rx_en   = 1'b1;
        #1;
        chk({tag, " key_en"}, {31'b0, key_en}, {31'b0, exp_key});
        if (exp_key) chk({tag, " key_data"}, {24'b0, key_data}, {24'b0, b});
        @(negedge clk50);
        rx_en   = 1'b0;
        rx_data = 8'h00;
    endtask

    // Cycles until the next send strobe or error pulse, bounded.
    task automatic wait_evt(output int n);
        n = 0;
        do begin
            @(negedge clk50);
            n++;
        end while (!cmd_send && !err && n < 300);
    endtask

    initial begin
        int n, m;

        // Reset state.
        repeat (3) @(negedge clk50);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst err", {31'b0, err}, 32'd0);
        chk("rst grant", {30'b0, grant}, 32'd0);
        chk("rst cmd_send", {31'b0, cmd_send}, 32'd0);
        chk("rst cmd_byte", {24'b0, cmd_byte}, 32'd0);
        chk("rst key_en", {31'b0, key_en}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk50);

        // LED sync: ED then 05, ACKs swallowed.
        led_val = 3'b101;
        led_req = 1'b1;
        @(negedge clk50);
        led_req = 1'b0;
        expect_send("t1 ED", 8'hED);
        chk("t1 grant", {30'b0, grant}, 32'd2);
        chk("t1 busy", {31'b0, busy}, 32'd1);
        reply("t1 ack1", 8'hFA, 1'b0);
        chk("t1 no_done_mid", {31'b0, done}, 32'd0);
        expect_send("t1 arg", 8'h05);
        reply("t1 ack2", 8'hFA, 1'b0);
        chk("t1 done", {31'b0, done}, 32'd1);
        chk("t1 grant_idle", {30'b0, grant}, 32'd0);
        chk("t1 busy_idle", {31'b0, busy}, 32'd0);
        @(negedge clk50);
        chk("t1 done_pulse", {31'b0, done}, 32'd0);

        // Simultaneous LED and rate: LED first.
        rate_val = 8'h20;
        led_req  = 1'b1;
        rate_req = 1'b1;
        @(negedge clk50);
        led_req  = 1'b0;
        rate_req = 1'b0;
        expect_send("t2 ED", 8'hED);
        chk("t2 grant_led", {30'b0, grant}, 32'd2);
        reply("t2 ack1", 8'hFA, 1'b0);
        expect_send("t2 arg_led", 8'h05);
        reply("t2 ack2", 8'hFA, 1'b0);
        chk("t2 done1", {31'b0, done}, 32'd1);
        expect_send("t2 F3", 8'hF3);
        chk("t2 grant_rate", {30'b0, grant}, 32'd3);
        reply("t2 ack3", 8'hFA, 1'b0);
        expect_send("t2 arg_rate", 8'h20);
        reply("t2 ack4", 8'hFA, 1'b0);
        chk("t2 done2", {31'b0, done}, 32'd1);
        @(negedge clk50);

        // RESEND twice then ACK; then four RESENDs abandon.
        led_req = 1'b1;
        @(negedge clk50);
        led_req = 1'b0;
        expect_send("t3 ED#1", 8'hED);
        reply("t3 fe1", 8'hFE, 1'b0);
        expect_send("t3 ED#2", 8'hED);
        reply("t3 fe2", 8'hFE, 1'b0);
        expect_send("t3 ED#3", 8'hED);
        reply("t3 ack", 8'hFA, 1'b0);
        expect_send("t3 arg", 8'h05);
        reply("t3 ack2", 8'hFA, 1'b0);
        chk("t3 done", {31'b0, done}, 32'd1);
        @(negedge clk50);
        led_req = 1'b1;
        @(negedge clk50);
        led_req = 1'b0;
        expect_send("t3b ED#1", 8'hED);
        reply("t3b fe1", 8'hFE, 1'b0);
        expect_send("t3b ED#2", 8'hED);
        reply("t3b fe2", 8'hFE, 1'b0);
        expect_send("t3b ED#3", 8'hED);
        reply("t3b fe3", 8'hFE, 1'b0);
        expect_send("t3b ED#4", 8'hED);
        reply("t3b fe4", 8'hFE, 1'b0);
        chk("t3b err", {31'b0, err}, 32'd1);
        chk("t3b no_done", {31'b0, done}, 32'd0);
        chk("t3b idle", {31'b0, busy}, 32'd0);
        @(negedge clk50);

        // No reply to F3: resend after 100 wait cycles, key byte passes mid-wait.
        rate_req = 1'b1;
        @(negedge clk50);
        rate_req = 1'b0;
        expect_send("t4 F3#1", 8'hF3);
        n = 0;
        repeat (30) begin
            @(negedge clk50);
            n++;
        end
        rx_data = 8'h1C;
        rx_en   = 1'b1;
        #1;
        chk("t4 key_en", {31'b0, key_en}, 32'd1);
        chk("t4 key_data", {24'b0, key_data}, 32'h1C);
        @(negedge clk50);
        n++;
        rx_en   = 1'b0;
        rx_data = 8'h00;
        wait_evt(m);
        n += m;
        chk("t4 tmo_cycles", n, 32'd101);
        expect_send("t4 F3#2", 8'hF3);
        wait_evt(m);
        chk("t4 tmo_cycles2", m, 32'd101);
        expect_send("t4 F3#3", 8'hF3);
        wait_evt(m);
        expect_send("t4 F3#4", 8'hF3);
        wait_evt(m);
        chk("t4 err", {31'b0, err}, 32'd1);
        chk("t4 no_send", {31'b0, cmd_send}, 32'd0);
        @(negedge clk50);

        // Keyboard reset.
        kbd_rst_req = 1'b1;
        @(negedge clk50);
        kbd_rst_req = 1'b0;
        expect_send("t5 FF", 8'hFF);
        chk("t5 grant", {30'b0, grant}, 32'd1);
        reply("t5 ack", 8'hFA, 1'b0);
`ifdef PS2_BAT_WAIT_EN
        chk("t5 bat_wait_busy", {31'b0, busy}, 32'd1);
        chk("t5 bat_wait_nodone", {31'b0, done}, 32'd0);
        reply("t5 bat", 8'hAA, 1'b0);
        chk("t5 done", {31'b0, done}, 32'd1);
        expect_send("t5 resync ED", 8'hED);
        reply("t5 ack2", 8'hFA, 1'b0);
        expect_send("t5 resync arg", 8'h05);
        reply("t5 ack3", 8'hFA, 1'b0);
        chk("t5 resync_done", {31'b0, done}, 32'd1);
`else
        chk("t5 done", {31'b0, done}, 32'd1);
        reply("t5 bat_pass", 8'hAA, 1'b1);
`endif
        @(negedge clk50);

        // Reset in WAIT_ACK aborts silently and drops pending requests.
        led_req = 1'b1;
        @(negedge clk50);
        led_req = 1'b0;
        expect_send("t6 ED", 8'hED);
        @(negedge clk50);
        rate_req = 1'b1;
        @(negedge clk50);
        rate_req = 1'b0;
        chk("t6 busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6 cmd_send", {31'b0, cmd_send}, 32'd0);
        chk("t6 busy", {31'b0, busy}, 32'd0);
        chk("t6 grant", {30'b0, grant}, 32'd0);
        @(negedge clk50);
        reset = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk50);
            if (cmd_send || busy || done || err) n++;
        end
        chk("t6 quiet_after", n, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before 400000 ns");
        $fatal(1, "watchdog");
    end

endmodule
